// File: rtl/knn_pkg.sv
// Shared definitions for the KNN majority-vote stage: vote FSM encoding,
// the unfilled-slot distance marker and a counter width helper.
package knn_pkg;

    typedef enum logic [1:0] {
        VS_IDLE   = 2'd0,
        VS_COUNT  = 2'd1,
        VS_SELECT = 2'd2,
        VS_DONE   = 2'd3
    } vote_state_e;

    localparam int KNN_DIST_W = 16;
    localparam logic [KNN_DIST_W-1:0] KNN_UNFILLED_DIST = '1;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/knn_vote_counter.sv
// Per-class vote counters and first-seen rank registers.
// The first-rank value K marks a class that has not been seen in this vote.
module knn_vote_counter
    import knn_pkg::*;
#(
    parameter int K      = 3,
    parameter int TYPE_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        inc,
    input  logic [TYPE_W-1:0]           inc_type,
    input  logic [cnt_width(K)-1:0]     inc_rank,
    input  logic [TYPE_W-1:0]           rd_idx,
    output logic [cnt_width(K)-1:0]     rd_count,
    output logic [cnt_width(K)-1:0]     rd_first_rank
);

    localparam int C      = 2 ** TYPE_W;
    localparam int RANK_W = cnt_width(K);
    localparam logic [RANK_W-1:0] UNSEEN = RANK_W'(K);

    logic [RANK_W-1:0] count      [0:C-1];
    logic [RANK_W-1:0] first_rank [0:C-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < C; c++) begin
                count[c]      <= '0;
                first_rank[c] <= '0;
            end
        end else if (clr) begin
            for (int c = 0; c < C; c++) begin
                count[c]      <= '0;
                first_rank[c] <= UNSEEN;
            end
        end else if (inc) begin
            count[inc_type] <= count[inc_type] + RANK_W'(1);
            // Ranks arrive in ascending order, so the first hit is the nearest.
            if (first_rank[inc_type] == UNSEEN) begin
                first_rank[inc_type] <= inc_rank;
            end
        end
    end

    assign rd_count      = count[rd_idx];
    assign rd_first_rank = first_rank[rd_idx];

endmodule

// File: rtl/knn_majority_vote.sv
// Majority vote over the K nearest sorted neighbours with nearest-first
// tie-break; publishes the winning class with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | wait for valid_sort, capture K nearest ranks, clear counters
// COUNT  | one rank per cycle, nearest first, tally filled slots
// SELECT | one class per cycle, keep best (count, then nearest first rank)
// DONE   | register result, pulse inference_done
module knn_majority_vote
    import knn_pkg::*;
#(
    parameter int N      = 8,
    parameter int K      = 3,
    parameter int W      = 16,
    parameter int TYPE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_sort,
    input  logic [W-1:0]              distance_array_sorted [0:N-1],
    input  logic [TYPE_W-1:0]         type_array_sorted     [0:N-1],
    output logic [TYPE_W-1:0]         inferred_type,
    output logic                      inference_done,
    output logic                      busy,
    output logic [$clog2(K+1)-1:0]    vote_count,
    output logic                      no_neighbours
);

    localparam int C       = 2 ** TYPE_W;
    localparam int RANK_W  = cnt_width(K);
    localparam int STEP_W  = cnt_width(((K > C) ? K : C) - 1);
    localparam int K_IDX_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE   = VS_IDLE;
    localparam logic [1:0] S_COUNT  = VS_COUNT;
    localparam logic [1:0] S_SELECT = VS_SELECT;
    localparam logic [1:0] S_DONE   = VS_DONE;

    localparam logic [W-1:0]      UNFILLED = '1;
    localparam logic [STEP_W-1:0] K_LAST   = STEP_W'(K - 1);
    localparam logic [STEP_W-1:0] C_LAST   = STEP_W'(C - 1);
    localparam logic [RANK_W-1:0] UNSEEN   = RANK_W'(K);

    logic [1:0]         state;
    logic [STEP_W-1:0]  step_cnt;
    logic [TYPE_W-1:0]  cap_type   [0:K-1];
    logic               cap_filled [0:K-1];

    logic [TYPE_W-1:0]  best_type;
    logic [RANK_W-1:0]  best_count;
    logic [RANK_W-1:0]  best_rank;

    logic               vc_clr;
    logic               vc_inc;
    logic [K_IDX_W-1:0] rank_idx;
    logic [TYPE_W-1:0]  class_idx;
    logic [RANK_W-1:0]  rd_count;
    logic [RANK_W-1:0]  rd_first_rank;
    logic               take_class;

    // step_cnt counts down; the scanned index is last - step so ranks and
    // classes are visited in ascending order.
    always_comb begin
        rank_idx   = K_IDX_W'(K_LAST - step_cnt);
        class_idx  = TYPE_W'(C_LAST - step_cnt);
        vc_clr     = (state == S_IDLE) && valid_sort;
        vc_inc     = (state == S_COUNT) && cap_filled[rank_idx];
        take_class = (rd_count > best_count) ||
                     ((rd_count == best_count) && (rd_count != '0) &&
                      (rd_first_rank < best_rank));
    end

    knn_vote_counter #(
        .K      (K),
        .TYPE_W (TYPE_W)
    ) u_vote_counter (
        .clk           (clk),
        .rst           (rst),
        .clr           (vc_clr),
        .inc           (vc_inc),
        .inc_type      (cap_type[rank_idx]),
        .inc_rank      (RANK_W'(rank_idx)),
        .rd_idx        (class_idx),
        .rd_count      (rd_count),
        .rd_first_rank (rd_first_rank)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            step_cnt       <= '0;
            best_type      <= '0;
            best_count     <= '0;
            best_rank      <= '0;
            inferred_type  <= '0;
            inference_done <= 1'b0;
            busy           <= 1'b0;
            vote_count     <= '0;
            no_neighbours  <= 1'b0;
            for (int r = 0; r < K; r++) begin
                cap_type[r]   <= '0;
                cap_filled[r] <= 1'b0;
            end
        end else begin
            inference_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= valid_sort;
                    if (valid_sort) begin
                        for (int r = 0; r < K; r++) begin
                            cap_type[r]   <= type_array_sorted[N-1-r];
                            cap_filled[r] <= (distance_array_sorted[N-1-r] != UNFILLED);
                        end
                        best_type  <= '0;
                        best_count <= '0;
                        best_rank  <= UNSEEN;
                        step_cnt   <= K_LAST;
                        state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    busy <= 1'b1;
                    if (step_cnt == '0) begin
                        step_cnt <= C_LAST;
                        state    <= S_SELECT;
                    end else begin
                        step_cnt <= step_cnt - STEP_W'(1);
                    end
                end
                S_SELECT: begin
                    busy <= 1'b1;
                    if (take_class) begin
                        best_type  <= class_idx;
                        best_count <= rd_count;
                        best_rank  <= rd_first_rank;
                    end
                    if (step_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        step_cnt <= step_cnt - STEP_W'(1);
                    end
                end
                S_DONE: begin
                    busy           <= 1'b1;
                    inference_done <= 1'b1;
                    if (best_count == '0) begin
                        inferred_type <= '1;
                        vote_count    <= '0;
                        no_neighbours <= 1'b1;
                    end else begin
                        inferred_type <= best_type;
                        vote_count    <= best_count;
                        no_neighbours <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
